// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard stall/flush controller.
package hazard_pkg;
  typedef enum logic {RUN, MEM_WAIT} hz_state_t;
  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_perf_counters.sv
// Three saturating event counters for load-use, branch and memory-wait hazards.
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu_evt,
  input  logic             br_evt,
  input  logic             mw_evt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mw_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt <= '0;
      br_cnt <= '0;
      mw_cnt <= '0;
    end else begin
      lu_cnt <= sat_inc(lu_cnt, lu_evt);
      br_cnt <= sat_inc(br_cnt, br_evt);
      mw_cnt <= sat_inc(mw_cnt, mw_evt);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with bounded data-memory wait.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  reg_idx_t Rs1_D,
  input  reg_idx_t Rs2_D,
  input  reg_idx_t RD_E,
  input  logic     RegWriteE,
  input  logic     ResultSrcE0,
  input  logic     PCSrcE,
  input  logic     MemReqM,
  input  logic     MemReadyM,
  output logic     StallF,
  output logic     StallD,
  output logic     StallE,
  output logic     StallM,
  output logic     FlushD,
  output logic     FlushE,
  output logic     FlushW,
  output logic     mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mw_cnt
`endif
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              lw_stall, mem_hold, mem_stall, err_set;

  assign lw_stall = ResultSrcE0 & RegWriteE & (RD_E != REG_ZERO) &
                    ((RD_E == Rs1_D) | (RD_E == Rs2_D));
  assign mem_hold = MemReqM & ~MemReadyM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

  // mem_stall is the only condition that freezes the pipe; timeout forces RUN-style release
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    mem_stall = 1'b0;
    err_set   = 1'b0;
    case (state)
      RUN: begin
        if (mem_hold) begin
          mem_stall = 1'b1;
          state_nxt = MEM_WAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNT_LAST) begin
          err_set   = 1'b1;
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else begin
          mem_stall = 1'b1;
          wcnt_nxt  = wcnt + WCNT_W'(1);
        end
      end
    endcase
  end

  // While the pipe is frozen, load-use and redirect wait until E re-evaluates on release
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = lw_stall | PCSrcE;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk    (clk),
    .rst    (rst),
    .lu_evt (lw_stall & ~mem_stall),
    .br_evt (PCSrcE & ~mem_stall),
    .mw_evt (mem_stall),
    .lu_cnt (lu_cnt),
    .br_cnt (br_cnt),
    .mw_cnt (mw_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MEM_TIMEOUT=4).
module tb_hazard_stall_ctrl;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, RD_E;
  logic       RegWriteE, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt, br_cnt, mw_cnt;
`endif

  hazard_stall_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1_D       (Rs1_D),
    .Rs2_D       (Rs2_D),
    .RD_E        (RD_E),
    .RegWriteE   (RegWriteE),
    .ResultSrcE0 (ResultSrcE0),
    .PCSrcE      (PCSrcE),
    .MemReqM     (MemReqM),
    .MemReadyM   (MemReadyM),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushW      (FlushW),
    .mem_err     (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_cnt      (lu_cnt),
    .br_cnt      (br_cnt),
    .mw_cnt      (mw_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output vector order: StallF StallD StallE StallM FlushD FlushE FlushW mem_err
  localparam logic [7:0] V_IDLE  = 8'b0000_0000;
  localparam logic [7:0] V_RST   = 8'b0000_1100;
  localparam logic [7:0] V_LU    = 8'b1100_0100;
  localparam logic [7:0] V_BR    = 8'b0000_1100;
  localparam logic [7:0] V_BRLU  = 8'b1100_1100;
  localparam logic [7:0] V_MEM   = 8'b1111_0010;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  wire [7:0] outv = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err};

  task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic pc,
                       input logic req, input logic rdy);
    Rs1_D = rs1; Rs2_D = rs2; RD_E = rd;
    RegWriteE = rw; ResultSrcE0 = ld; PCSrcE = pc;
    MemReqM = req; MemReadyM = rdy;
  endtask

  task automatic score();
    sb_t e;
    e = sb_q.pop_front();
    check_vec(e.tag, outv, e.exp);
  endtask

  task automatic expect_now(input string tag, input logic [7:0] exp);
    sb_q.push_back('{tag, exp});
    score();
  endtask

  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic rw, input logic ld, input logic pc,
                      input logic req, input logic rdy, input logic [7:0] exp);
    @(posedge clk);
    #1;
    drive(rs1, rs2, rd, rw, ld, pc, req, rdy);
    sb_q.push_back('{tag, exp});
    @(negedge clk);
    score();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    expect_now("reset", V_RST);
    drive(5, 0, 5, 1, 1, 0, 1, 0);
    #1;
    expect_now("reset_inputs_busy", V_RST);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // load-use
    step("idle",       0, 0, 0, 0, 0, 0, 0, 0, V_IDLE);
    step("lu_rs1",     5, 0, 5, 1, 1, 0, 0, 0, V_LU);
    step("lu_rs2",     3, 5, 5, 1, 1, 0, 0, 0, V_LU);
    step("lu_x0",      0, 0, 0, 1, 1, 0, 0, 0, V_IDLE);
    step("lu_noload",  5, 0, 5, 1, 0, 0, 0, 0, V_IDLE);
    step("lu_nowrite", 5, 0, 5, 0, 1, 0, 0, 0, V_IDLE);
    step("lu_nomatch", 6, 7, 5, 1, 1, 0, 0, 0, V_IDLE);

    // branch
    step("br",         0, 0, 0, 0, 0, 1, 0, 0, V_BR);
    step("br_lu",      5, 0, 5, 1, 1, 1, 0, 0, V_BRLU);

    // 3-cycle memory wait
    step("mw_0",       0, 0, 0, 0, 0, 0, 1, 0, V_MEM);
    step("mw_1",       0, 0, 0, 0, 0, 0, 1, 0, V_MEM);
    step("mw_2",       0, 0, 0, 0, 0, 0, 1, 0, V_MEM);
    step("mw_rel",     0, 0, 0, 0, 0, 0, 1, 1, V_IDLE);
    step("mw_after",   0, 0, 0, 0, 0, 0, 0, 0, V_IDLE);

    // zero-wait and back-to-back
    step("mw_ready",   0, 0, 0, 0, 0, 0, 1, 1, V_IDLE);
    step("b2b_0",      0, 0, 0, 0, 0, 0, 1, 0, V_MEM);
    step("b2b_rel",    0, 0, 0, 0, 0, 0, 1, 1, V_IDLE);
    step("b2b_next",   0, 0, 0, 0, 0, 0, 1, 0, V_MEM);
    step("b2b_rel2",   0, 0, 0, 0, 0, 0, 1, 1, V_IDLE);

    // deferral of load-use / redirect while frozen
    step("df_0",       5, 0, 5, 1, 1, 1, 1, 0, V_MEM);
    step("df_1",       5, 0, 5, 1, 1, 1, 1, 0, V_MEM);
    step("df_rel",     0, 0, 0, 0, 0, 1, 0, 1, V_BR);

    // timeout at MEM_TIMEOUT=4
    step("to_0",       0, 0, 0, 0, 0, 0, 1, 0, V_MEM);
    step("to_1",       0, 0, 0, 0, 0, 0, 1, 0, V_MEM);
    step("to_2",       0, 0, 0, 0, 0, 0, 1, 0, V_MEM);
    step("to_rel",     0, 0, 0, 0, 0, 0, 1, 0, V_IDLE);
    step("to_err",     0, 0, 0, 0, 0, 0, 0, 0, V_IDLE | 8'b1);
    step("to_sticky",  5, 0, 5, 1, 1, 0, 0, 0, V_LU | 8'b1);

    // async reset in the middle of a wait
    step("ar_wait0",   0, 0, 0, 0, 0, 0, 1, 0, V_MEM | 8'b1);
    step("ar_wait1",   0, 0, 0, 0, 0, 0, 1, 0, V_MEM | 8'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    expect_now("async_rst", V_RST);
`ifdef HAZARD_PERF_CNT_EN
    check_vec("lu_cnt_rst", lu_cnt, 8'd0);
    check_vec("br_cnt_rst", br_cnt, 8'd0);
    check_vec("mw_cnt_rst", mw_cnt, 8'd0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst",   0, 0, 0, 0, 0, 0, 0, 0, V_IDLE);
    step("post_rst_b", 0, 0, 0, 0, 0, 0, 1, 0, V_MEM);
    step("post_rel",   0, 0, 0, 0, 0, 0, 0, 1, V_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
